// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and
// result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin, one
// full-subtractor cell and a borrow flop, WIDTH cycles per result.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave io
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             bout_q;
  logic             ovf_q;

  logic             d;
  logic             borrow_n;
  logic             take;
  logic [WIDTH-1:0] r_nxt;

  assign d        = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_n = (~a_sr[0] & b_sr[0]) |
                    (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign r_nxt    = {d, r_sr[WIDTH-1:1]};
  assign take     = io.start &&
                    (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        take: begin
          state  <= SHIFT;
          a_sr   <= io.a;
          b_sr   <= io.b;
          r_sr   <= '0;
          borrow <= io.bin;
          cnt    <= '0;
          a_msb  <= io.a[WIDTH-1];
          b_msb  <= io.b[WIDTH-1];
        end
        (state == SHIFT): begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr   <= r_nxt;
          borrow <= borrow_n;
          cnt    <= cnt + 1'b1;
          // last bit: d is the result MSB
          if (cnt == LAST) begin
            state  <= DONE;
            diff_q <= r_nxt;
            bout_q <= borrow_n;
            ovf_q  <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy = (state == SHIFT);
  assign io.done = (state == DONE);
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for WIDTH=8 directed
// cases and WIDTH=4 exhaustive back-to-back operation.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) io8 ();
  serial_subtractor_if #(.WIDTH(4)) io4 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .io  (io8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk (clk),
    .rst (rst),
    .io  (io4)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [9:0] q8[$];
  logic [5:0] q4[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ref8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       bi);
    logic [8:0] f;
    logic [7:0] dd;
    f  = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    dd = f[7:0];
    return {f[8], (a[7] != b[7]) && (dd[7] != a[7]), dd};
  endfunction

  function automatic logic [5:0] ref4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       bi);
    logic [4:0] f;
    logic [3:0] dd;
    f  = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    dd = f[3:0];
    return {f[4], (a[3] != b[3]) && (dd[3] != a[3]), dd};
  endfunction

  always @(negedge clk) begin
    logic [9:0] e8;
    logic [5:0] e4;
    chk("excl8", 32'(io8.busy & io8.done), 0);
    chk("excl4", 32'(io4.busy & io4.done), 0);
    if (io8.done) begin
      chk("sb8_empty", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("sb8", {io8.bout, io8.ovf, io8.diff}, e8);
      end
    end
    if (io4.done) begin
      chk("sb4_empty", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("sb4", {io4.bout, io4.ovf, io4.diff}, e4);
      end
    end
  end

  task automatic launch8(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic       bi);
    io8.a     = a;
    io8.b     = b;
    io8.bin   = bi;
    io8.start = 1'b1;
    q8.push_back(ref8(a, b, bi));
    @(posedge clk);
    #1;
    io8.start = 1'b0;
  endtask

  task automatic wait8(input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!io8.done) chk({tag, "_busy"}, 32'(io8.busy), 1);
    end while (!io8.done && n < 20);
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic       bi,
                     input string      tag);
    launch8(a, b, bi);
    wait8(8, tag);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, 32'(io8.done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    io8.start = 1'b0;
    io8.a     = '0;
    io8.b     = '0;
    io8.bin   = 1'b0;
    io4.start = 1'b0;
    io4.a     = '0;
    io4.b     = '0;
    io4.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(io8.busy), 0);
    chk("rst_done", 32'(io8.done), 0);
    chk("rst_diff", 32'(io8.diff), 0);
    chk("rst_bout", 32'(io8.bout), 0);
    chk("rst_ovf", 32'(io8.ovf), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op8(8'h05, 8'h03, 1'b0, "t05_03");
    op8(8'h03, 8'h05, 1'b0, "t03_05");
    op8(8'h00, 8'h00, 1'b1, "t00_00b");
    op8(8'h80, 8'h01, 1'b0, "t80_01");
    op8(8'h7F, 8'hFF, 1'b0, "t7f_ff");

    // start pulsed mid-operation must be ignored
    launch8(8'h05, 8'h03, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("hold_diff", 32'(io8.diff), 32'h80);
    io8.a     = 8'h10;
    io8.b     = 8'h01;
    io8.bin   = 1'b1;
    io8.start = 1'b1;
    @(posedge clk);
    #1;
    io8.start = 1'b0;
    wait8(4, "ign");
    repeat (10) @(posedge clk);
    #1;

    // back-to-back through the DONE cycle
    launch8(8'h11, 8'h22, 1'b0);
    wait8(8, "b2b1");
    launch8(8'hA5, 8'h5A, 1'b1);
    chk("b2b_busy", 32'(io8.busy), 1);
    wait8(8, "b2b2");
    @(posedge clk);
    #1;

    // reset mid-SHIFT aborts with no done pulse
    launch8(8'h05, 8'h03, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    q8.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", 32'(io8.busy), 0);
    chk("mrst_diff", 32'(io8.diff), 0);
    chk("mrst_bout", 32'(io8.bout), 0);
    chk("mrst_ovf", 32'(io8.ovf), 0);
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("mrst_nodone", 32'(io8.done), 0);
    end

    // WIDTH=4 exhaustive, start held high for back-to-back
    for (int i = 0; i < 512; i++) begin
      io4.a     = i[3:0];
      io4.b     = i[7:4];
      io4.bin   = i[8];
      io4.start = 1'b1;
      q4.push_back(ref4(io4.a, io4.b, io4.bin));
      @(posedge clk);
      #1;
      n = 0;
      while (!io4.done && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("lat4", n, 4);
    end
    io4.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", 32'(q8.size() + q4.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first ripple subtractor: one full-subtractor cell plus a borrow flip-flop, sequenced by a small FSM.
- Computes `a - b - bin` over WIDTH clock cycles and reports difference, borrow-out and signed overflow.
- Counterpart to the team's combinational full-adder cell. Used where area matters more than latency.
- Sits behind a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request: sample operands and begin; honoured only in IDLE or DONE.
- a  input  WIDTH  minuend; sampled only on the accepted start edge.
- b  input  WIDTH  subtrahend; sampled only on the accepted start edge.
- bin  input  1  borrow-in; sampled only on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  single-cycle pulse: result registers valid/updated.
- diff  output  WIDTH  registered difference; holds last result until next completion.
- bout  output  1  registered borrow-out of the MSB.
- ovf  output  1  registered two's-complement overflow flag.

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal: state=IDLE, shift regs=0, borrow FF=0, counter=0.
  - Reset wins over every other input in the same cycle. Reset mid-SHIFT aborts the operation; no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 → load a_sr=a, b_sr=b, borrow=bin, cnt=0; latch a[WIDTH-1], b[WIDTH-1] for the ovf calculation.
  - State → SHIFT, busy=1.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - d = a_sr[0]^b_sr[0]^borrow.
  - borrow' = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
  - a_sr and b_sr shift right by 1; d is shifted into the MSB of the internal result shift reg; cnt++.
  - start is ignored in SHIFT; operands may change freely without effect.
- Completion:
  - On the edge where cnt reaches WIDTH-1→WIDTH (edge E_WIDTH): diff ← final result reg (including the bit computed on this edge), bout ← borrow', ovf ← (a_msb≠b_msb)&&(diff_msb≠a_msb).
  - State → DONE, busy=0, done=1.
  - done therefore rises exactly WIDTH clocks after the start-sampling edge.
- DONE, lasts one cycle:
  - done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operation: next state SHIFT, busy=1, done=0. Throughput is one result per WIDTH+1 cycles.
  - Otherwise → IDLE, done=0.
- diff/bout/ovf change only on the completion edge or reset; they never expose intermediate shift contents.
- Arithmetic: modulo 2^WIDTH.
  - bout=1 iff unsigned a < b+bin.
  - ovf per signed interpretation of a, b; bin does not enter the ovf formula except through diff.
- busy and done are never simultaneously high.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start one cycle → busy high 8 cycles; done pulses exactly 8 clocks after start edge; diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0; a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Mid-op checks:
  - Start with 0x05-0x03; pulse start again with other operands during SHIFT → ignored, diff=0x02.
  - Assert rst at cycle 4 → busy=0, done never pulses, diff=0.
- Back-to-back: hold start high with new operands in the DONE cycle → second operation begins without an IDLE cycle; second done arrives 9 clocks after first done; both results correct.
- WIDTH=4 exhaustive: all 512 (a, b, bin) combos → {bout, diff} equals (a - b - bin) mod 32 interpretation; ovf matches a signed reference model.
